// File: rtl/regfile_pkg.sv
// Shared sizing constants and helpers for the register file / scoreboard slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREG  = 32;
   localparam int DEF_CNT_W = 2;
   localparam int ZERO_REG  = 0;

   // Address width for a register file of nreg entries (at least one bit).
   function automatic int addr_w(input int nreg);
      return (nreg > 1) ? $clog2(nreg) : 1;
   endfunction

endpackage

// File: rtl/pend_counter.sv
// Per-register pending-write counter: issue increments, writeback decrements, flush clears.
// Latency: count updates on the rising edge after inc/dec/clr; sat/zero flags are combinational.
// Backpressure: none internally; caller must gate inc with sat and dec with zero.
module pend_counter
   import regfile_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             sat,
   output logic             zero
);

   // Count state: clear wins, simultaneous inc/dec cancel out.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !dec) begin
         cnt <= cnt + CNT_W'(1);
      end else if (dec && !inc) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Status flags used for issue stall and underflow gating.
   always_comb begin
      sat  = &cnt;
      zero = ~|cnt;
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with 2 combinational read ports, 1 write port and per-register pending-write scoreboard.
// Latency: writes and counter updates take effect at the next rising edge; optional same-cycle bypass on reads/busy.
// Backpressure: iss_stall rejects an issue whose destination counter is saturated; writeback is never stalled.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int XLEN    = DEF_XLEN,
   parameter  int NREG    = DEF_NREG,
   parameter  bit ZERO_R0 = 1'b1,
   parameter  bit BYPASS  = 1'b1,
   parameter  int CNT_W   = DEF_CNT_W,
   localparam int AW      = addr_w(NREG)
) (
   input  logic            CLK,
   input  logic            rst,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy1,
   output logic            busy2,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic            iss_stall,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic            flush,
   output logic            err_uflow
);

   logic [XLEN-1:0]  mem [NREG];
   logic [CNT_W-1:0] cnt [NREG];
   logic [NREG-1:0]  inc;
   logic [NREG-1:0]  dec;
   logic [NREG-1:0]  sat;
   logic [NREG-1:0]  zero;
   logic             wr_en;
   logic             iss_ok;
   logic             iss_dec;
   logic             rel1;
   logic             rel2;

   // Writability of the target registers and issue stall; a same-cycle release on
   // a saturated destination frees a slot, so the issue is accepted.
   always_comb begin
      wr_en     = we && !(ZERO_R0 && (waddr == AW'(ZERO_REG)));
      iss_ok    = iss_valid && !(ZERO_R0 && (iss_rd == AW'(ZERO_REG)));
      iss_dec   = we && (waddr == iss_rd) && !zero[iss_rd];
      iss_stall = iss_ok && sat[iss_rd] && !iss_dec;
   end

   // Per-register increment/decrement strobes; decrement is gated at zero so counters never wrap.
   always_comb begin
      inc = '0;
      dec = '0;
      for (int r = 0; r < NREG; r++) begin
         inc[r] = iss_ok && !iss_stall && (iss_rd == AW'(r));
         dec[r] = we && (waddr == AW'(r)) && !zero[r];
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_cnt
      pend_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .CLK  (CLK),
         .rst  (rst),
         .inc  (inc[g]),
         .dec  (dec[g]),
         .clr  (flush),
         .cnt  (cnt[g]),
         .sat  (sat[g]),
         .zero (zero[g])
      );
   end

   // Architectural data array; writes still commit during a flush.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) begin
            mem[r] <= '0;
         end
      end else if (wr_en) begin
         mem[waddr] <= wdata;
      end
   end

   // Sticky flag for a writeback that had no matching reservation.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         err_uflow <= 1'b0;
      end else if (wr_en && zero[waddr] && !flush) begin
         err_uflow <= 1'b1;
      end
   end

   // Read ports with optional writeback forwarding and early release of busy.
   always_comb begin
      rel1 = BYPASS && (cnt[ra1] == CNT_W'(1)) && dec[ra1] && !inc[ra1];
      rel2 = BYPASS && (cnt[ra2] == CNT_W'(1)) && dec[ra2] && !inc[ra2];

      if (ZERO_R0 && (ra1 == AW'(ZERO_REG))) begin
         rd1   = '0;
         busy1 = 1'b0;
      end else begin
         rd1   = (BYPASS && wr_en && (waddr == ra1)) ? wdata : mem[ra1];
         busy1 = !zero[ra1] && !rel1;
      end

      if (ZERO_R0 && (ra2 == AW'(ZERO_REG))) begin
         rd2   = '0;
         busy2 = 1'b0;
      end else begin
         rd2   = (BYPASS && wr_en && (waddr == ra2)) ? wdata : mem[ra2];
         busy2 = !zero[ra2] && !rel2;
      end
   end

endmodule
